// File: rtl/block_frame_player_if.sv
// block_frame_player_if: frame fetch handshake between the player (master) and its frame store (slave).
interface block_frame_player_if #(
   parameter int FW = 12,
   parameter int DW = 1200
);
   logic          frame_req;
   logic [FW-1:0] frame_req_num;
   logic          frame_ack;
   logic [DW-1:0] frame_data;
   modport master (output frame_req, frame_req_num, input frame_ack, frame_data);
   modport slave (input frame_req, frame_req_num, output frame_ack, frame_data);
endinterface

// File: rtl/block_frame_player.sv
// block_frame_player: double-buffered block-video player paced by VGA vsync.
// Define BLOCK_FRAME_LOOP_EN to wrap playback to frame 0 instead of stopping after the last frame.
module block_frame_player #(
   parameter int HPIXELS     = 640,
   parameter int VPIXELS     = 480,
   parameter int BLOCK_SIZE  = 16,
   parameter int BPP         = 1,
   parameter int NUM_FRAMES  = 2608,
   parameter int FRAME_DIV   = 5,
   parameter int AUDIO_START = 184,
   localparam int GW         = HPIXELS / BLOCK_SIZE,
   localparam int GH         = VPIXELS / BLOCK_SIZE,
   localparam int NBLK       = GW * GH,
   localparam int FW         = $clog2(NUM_FRAMES)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_vsync_in,
   input  logic [9:0]          i_hc,
   input  logic [9:0]          i_vc,
   input  logic                i_play_en,
   input  logic                i_step,
   block_frame_player_if.master bus,
   output logic [11:0]         o_rgb,
   output logic [FW-1:0]       o_frame_num,
   output logic                o_frame_tick,
   output logic                o_audio_play,
   output logic                o_overrun,
   output logic                o_done
);
   localparam int DW = NBLK * BPP;
   localparam int BW = $clog2(DW);
   localparam int DIVW = $clog2(FRAME_DIV + 1);
   localparam logic [FW-1:0] LAST = FW'(NUM_FRAMES - 1);

   logic            r_vs1, r_vs2, r_vs3;
   logic [DIVW-1:0] r_div;
   logic            r_step, r_back_full, r_more, r_req;
   logic [DW-1:0]   r_front, r_back;
   logic [FW-1:0]   r_back_idx, r_req_num, r_frame_num;
   logic [11:0]     r_rgb;
   logic            r_tick, r_audio, r_overrun, r_done;

   logic            w_fall, w_opp, w_adv, w_ack, w_inside;
   logic [31:0]     w_blk;
   logic [BW-1:0]   w_base;
   logic [BPP-1:0]  w_v;
   logic [4*BPP-1:0] w_rep;
   logic [3:0]      w_gray;

   assign w_fall   = r_vs3 & ~r_vs2;
   assign w_opp    = w_fall && r_div == DIVW'(FRAME_DIV - 1);
   assign w_adv    = w_opp && (i_play_en || r_step) && r_back_full && !r_done;
   assign w_ack    = r_req && bus.frame_ack;
   assign w_inside = 32'(i_hc) < 32'(HPIXELS) && 32'(i_vc) < 32'(VPIXELS);
   assign w_blk    = w_inside ? (32'(i_vc) / 32'(BLOCK_SIZE)) * 32'(GW) + 32'(i_hc) / 32'(BLOCK_SIZE) : '0;
   assign w_base   = BW'(w_blk * 32'(BPP));
   assign w_v      = r_front[w_base +: BPP];
   // Replicating v MSB-first and keeping the top nibble spreads any BPP across the full 4-bit range.
   assign w_rep    = {4{w_v}};
   assign w_gray   = w_rep[4*BPP-1 -: 4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs1       <= 1'b1;
         r_vs2       <= 1'b1;
         r_vs3       <= 1'b1;
         r_div       <= '0;
         r_step      <= 1'b0;
         r_back_full <= 1'b0;
         r_more      <= 1'b1;
         r_req       <= 1'b0;
         r_front     <= '0;
         r_back      <= '0;
         r_back_idx  <= '0;
         r_req_num   <= '0;
         r_frame_num <= '0;
         r_rgb       <= '0;
         r_tick      <= 1'b0;
         r_audio     <= 1'b0;
         r_overrun   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_vs1   <= i_vsync_in;
         r_vs2   <= r_vs1;
         r_vs3   <= r_vs2;
         if (w_fall) r_div <= w_opp ? '0 : r_div + 1'b1;
         r_step  <= (r_step | i_step) & ~w_adv;
         r_tick  <= w_adv;
         r_audio <= 32'(r_frame_num) >= 32'(AUDIO_START);
         r_rgb   <= w_inside ? {3{w_gray}} : 12'h000;
         if (w_opp && i_play_en && !r_back_full && !r_done) r_overrun <= 1'b1;
         if (w_adv) begin
            r_front     <= r_back;
            r_frame_num <= r_back_idx;
`ifndef BLOCK_FRAME_LOOP_EN
            if (r_back_idx == LAST) r_done <= 1'b1;
`endif
         end
         // An ack landing on an advance refills the buffer that the advance just emptied.
         r_back_full <= w_ack | (r_back_full & ~w_adv);
         if (w_ack) begin
            r_back     <= bus.frame_data;
            r_back_idx <= r_req_num;
            r_req_num  <= r_req_num == LAST ? '0 : r_req_num + 1'b1;
`ifndef BLOCK_FRAME_LOOP_EN
            r_more     <= r_req_num != LAST;
`endif
         end
         r_req <= r_req ? !bus.frame_ack : (!r_back_full && r_more);
      end
   end

   assign bus.frame_req     = r_req;
   assign bus.frame_req_num = r_req_num;
   assign o_rgb             = r_rgb;
   assign o_frame_num       = r_frame_num;
   assign o_frame_tick      = r_tick;
   assign o_audio_play      = r_audio;
   assign o_overrun         = r_overrun;
   assign o_done            = r_done;
endmodule

// File: tb/tb_block_frame_player.sv
// tb_block_frame_player: directed bench on a 4x2 block grid, BPP=2, four frames, audio from frame 2.
module tb_block_frame_player;
   localparam int FW = 2;
   localparam int DW = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vs = 1'b1;
   logic        play = 1'b0;
   logic        step = 1'b0;
   logic [9:0]  hc = '0;
   logic [9:0]  vc = '0;
   logic [11:0] rgb;
   logic [FW-1:0] fnum;
   logic        tick, audio, ovr, done;
   int          errors = 0;
   int          checks = 0;
   int          n_ticks = 0;
   int          cyc = 0;
   int          t_cyc = 0;
   int          a_cyc = 0;
   logic        prev_a = 1'b0;

   block_frame_player_if #(.FW(FW), .DW(DW)) bus();

   block_frame_player #(
      .HPIXELS(64), .VPIXELS(32), .BLOCK_SIZE(16), .BPP(2),
      .NUM_FRAMES(4), .FRAME_DIV(5), .AUDIO_START(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_vsync_in(vs), .i_hc(hc), .i_vc(vc),
      .i_play_en(play), .i_step(step), .bus(bus),
      .o_rgb(rgb), .o_frame_num(fnum), .o_frame_tick(tick),
      .o_audio_play(audio), .o_overrun(ovr), .o_done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (tick) begin
         n_ticks++;
         t_cyc = cyc;
      end
      if (audio && !prev_a) a_cyc = cyc;
      prev_a = audio;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic vfall(input int n);
      repeat (n) begin
         vs = 1'b0;
         clk_n(4);
         vs = 1'b1;
         clk_n(4);
      end
   endtask

   task automatic serve(input logic [FW-1:0] num, input logic [DW-1:0] d);
      int k = 0;
      while (!bus.frame_req && k < 20) begin
         clk_n(1);
         k++;
      end
      checks++;
      if (bus.frame_req !== 1'b1) begin
         errors++;
         $display("FAIL serve_req frame %0d: frame_req=%b, expected 1 within 20 cycles", num, bus.frame_req);
      end else begin
         checks++;
         if (bus.frame_req_num !== num) begin
            errors++;
            $display("FAIL serve_req_num: got %0d expected %0d", bus.frame_req_num, num);
         end
         bus.frame_ack = 1'b1;
         bus.frame_data = d;
         clk_n(1);
         bus.frame_ack = 1'b0;
         checks++;
         if (bus.frame_req !== 1'b0) begin
            errors++;
            $display("FAIL serve_drop frame %0d: frame_req=%b expected 0", num, bus.frame_req);
         end
      end
   endtask

   task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic [11:0] exp);
      hc = h;
      vc = v;
      clk_n(1);
      checks++;
      if (rgb !== exp) begin
         errors++;
         $display("FAIL pixel hc=%0d vc=%0d: rgb=%h expected %h", h, v, rgb, exp);
      end
   endtask

   task automatic test_reset;
      bus.frame_ack = 1'b0;
      bus.frame_data = '0;
      rst_n = 1'b0;
      clk_n(2);
      checks++;
      if ({rgb, fnum, tick, audio, ovr, done, bus.frame_req} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rgb=%h fnum=%0d tick=%b audio=%b ovr=%b done=%b req=%b expected all 0",
                  rgb, fnum, tick, audio, ovr, done, bus.frame_req);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      clk_n(1);
      checks++;
      if (bus.frame_req !== 1'b1 || bus.frame_req_num !== 2'd0) begin
         errors++;
         $display("FAIL reset_first_req: req=%b num=%0d expected req=1 num=0", bus.frame_req, bus.frame_req_num);
      end
   endtask

   task automatic test_advance;
      serve(2'd0, 16'h0C42);
      play = 1'b1;
      n_ticks = 0;
      vfall(4);
      checks++;
      if (n_ticks !== 0) begin
         errors++;
         $display("FAIL advance_early: ticks=%0d after 4 falls expected 0", n_ticks);
      end
      vfall(1);
      checks++;
      if (n_ticks !== 1 || fnum !== 2'd0) begin
         errors++;
         $display("FAIL advance: ticks=%0d fnum=%0d expected ticks=1 fnum=0", n_ticks, fnum);
      end
      checks++;
      if (bus.frame_req !== 1'b1 || bus.frame_req_num !== 2'd1 || ovr !== 1'b0) begin
         errors++;
         $display("FAIL advance_next_req: req=%b num=%0d ovr=%b expected req=1 num=1 ovr=0",
                  bus.frame_req, bus.frame_req_num, ovr);
      end
   endtask

   task automatic test_pixel;
      logic [9:0]  h [6] = '{10'd5, 10'd700, 10'd50, 10'd5, 10'd20, 10'd30};
      logic [9:0]  v [6] = '{10'd5, 10'd5, 10'd0, 10'd40, 10'd20, 10'd5};
      logic [11:0] e [6] = '{12'hAAA, 12'h000, 12'h555, 12'h000, 12'hFFF, 12'h000};
      for (int i = 0; i < 6; i++) pix(h[i], v[i], e[i]);
   endtask

   task automatic test_overrun;
      n_ticks = 0;
      vfall(5);
      checks++;
      if (n_ticks !== 0 || fnum !== 2'd0 || ovr !== 1'b1) begin
         errors++;
         $display("FAIL overrun: ticks=%0d fnum=%0d ovr=%b expected ticks=0 fnum=0 ovr=1", n_ticks, fnum, ovr);
      end
      serve(2'd1, 16'h0003);
      clk_n(3);
      checks++;
      if (ovr !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky: ovr=%b expected 1", ovr);
      end
   endtask

   task automatic test_step;
      play = 1'b0;
      n_ticks = 0;
      vfall(5);
      checks++;
      if (n_ticks !== 0 || fnum !== 2'd0) begin
         errors++;
         $display("FAIL paused: ticks=%0d fnum=%0d expected ticks=0 fnum=0", n_ticks, fnum);
      end
      step = 1'b1;
      clk_n(1);
      step = 1'b0;
      vfall(5);
      checks++;
      if (n_ticks !== 1 || fnum !== 2'd1) begin
         errors++;
         $display("FAIL step_advance: ticks=%0d fnum=%0d expected ticks=1 fnum=1", n_ticks, fnum);
      end
      pix(10'd5, 10'd5, 12'hFFF);
      serve(2'd2, 16'h0001);
      bus.frame_ack = 1'b1;
      bus.frame_data = 16'h0003;
      clk_n(1);
      bus.frame_ack = 1'b0;
      checks++;
      if (bus.frame_req !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack: frame_req=%b expected 0", bus.frame_req);
      end
      vfall(5);
      checks++;
      if (n_ticks !== 1 || fnum !== 2'd1 || audio !== 1'b0) begin
         errors++;
         $display("FAIL step_once: ticks=%0d fnum=%0d audio=%b expected ticks=1 fnum=1 audio=0", n_ticks, fnum, audio);
      end
   endtask

   task automatic test_audio;
      play = 1'b1;
      n_ticks = 0;
      vfall(5);
      checks++;
      if (n_ticks !== 1 || fnum !== 2'd2 || audio !== 1'b1) begin
         errors++;
         $display("FAIL audio_frame: ticks=%0d fnum=%0d audio=%b expected ticks=1 fnum=2 audio=1", n_ticks, fnum, audio);
      end
      checks++;
      if (a_cyc !== t_cyc + 1) begin
         errors++;
         $display("FAIL audio_latency: audio rose at cycle %0d, tick at %0d, expected tick+1", a_cyc, t_cyc);
      end
      pix(10'd5, 10'd5, 12'h555);
   endtask

   task automatic test_end;
      serve(2'd3, 16'h0002);
      vfall(5);
      checks++;
      if (n_ticks !== 2 || fnum !== 2'd3) begin
         errors++;
         $display("FAIL last_frame: ticks=%0d fnum=%0d expected ticks=2 fnum=3", n_ticks, fnum);
      end
`ifdef BLOCK_FRAME_LOOP_EN
      clk_n(2);
      checks++;
      if (bus.frame_req !== 1'b1 || bus.frame_req_num !== 2'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL loop_wrap: req=%b num=%0d done=%b expected req=1 num=0 done=0", bus.frame_req, bus.frame_req_num, done);
      end
`else
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done: done=%b expected 1", done);
      end
      clk_n(10);
      checks++;
      if (bus.frame_req !== 1'b0) begin
         errors++;
         $display("FAIL no_more_req: frame_req=%b expected 0", bus.frame_req);
      end
      vfall(5);
      checks++;
      if (n_ticks !== 2 || fnum !== 2'd3 || done !== 1'b1) begin
         errors++;
         $display("FAIL stopped: ticks=%0d fnum=%0d done=%b expected ticks=2 fnum=3 done=1", n_ticks, fnum, done);
      end
`endif
   endtask

   task automatic test_reset_mid;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rgb, fnum, audio, ovr, done, bus.frame_req} !== '0) begin
         errors++;
         $display("FAIL reset_again: rgb=%h fnum=%0d audio=%b ovr=%b done=%b req=%b expected all 0",
                  rgb, fnum, audio, ovr, done, bus.frame_req);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      clk_n(1);
      checks++;
      if (bus.frame_req !== 1'b1 || bus.frame_req_num !== 2'd0) begin
         errors++;
         $display("FAIL reset_again_req: req=%b num=%0d expected req=1 num=0", bus.frame_req, bus.frame_req_num);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.frame_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_handshake: frame_req=%b expected 0", bus.frame_req);
      end
      clk_n(1);
      rst_n = 1'b1;
      clk_n(2);
   endtask

   initial begin
      test_reset;
      test_advance;
      test_pixel;
      test_overrun;
      test_step;
      test_audio;
      test_end;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
